// File: rtl/fib_kernel_arbiter_if.sv
// -----------------------------------------------------------------------------
// fib_kernel_arbiter_if
// Bundles the requester, response and kernel-side signals of the Fibonacci
// kernel arbiter.
//   slave  : arbiter view (takes requests, drives responses and kernel operands)
//   master : environment view (requesters, response consumer, kernel)
// Requester i occupies req_n[6i+5:6i], req_a/req_b[32i+31:32i].
// -----------------------------------------------------------------------------
interface fib_kernel_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // requester side
    logic [NREQ-1:0]    req_valid;
    logic [6*NREQ-1:0]  req_n;
    logic [32*NREQ-1:0] req_a;
    logic [32*NREQ-1:0] req_b;
    logic [NREQ-1:0]    req_ready;

    // response side
    logic               resp_valid;
    logic               resp_ready;
    logic [IW-1:0]      resp_id;
    logic [31:0]        resp_data;
    logic               resp_err;
    logic               busy;

    // kernel side
    logic               k_r_enable;
    logic               k_controlArr;
    logic [5:0]         k_init_n;
    logic [31:0]        k_init_a;
    logic [31:0]        k_init_b;
    logic               k_w_enable;
    logic [31:0]        k_result;

    modport slave (
        input  req_valid, req_n, req_a, req_b, resp_ready, k_w_enable, k_result,
        output req_ready, resp_valid, resp_id, resp_data, resp_err, busy,
               k_r_enable, k_controlArr, k_init_n, k_init_a, k_init_b
    );

    modport master (
        output req_valid, req_n, req_a, req_b, resp_ready, k_w_enable, k_result,
        input  req_ready, resp_valid, resp_id, resp_data, resp_err, busy,
               k_r_enable, k_controlArr, k_init_n, k_init_a, k_init_b
    );
endinterface

// File: rtl/fib_kernel_arbiter.sv
// -----------------------------------------------------------------------------
// fib_kernel_arbiter
// Round-robin scheduler sharing one Fibonacci kernel between NREQ requesters.
// A job (n, a, b) is accepted from one requester, loaded into the kernel with a
// one-cycle k_r_enable pulse, and the kernel result is returned on a single
// valid/ready response port tagged with the requester index. A watchdog turns
// a kernel that never raises k_w_enable into an error response.
//
// Ports:
//   clk    : sole clock, rising edge
//   rst_n  : synchronous active-low reset
//   bus    : fib_kernel_arbiter_if.slave (requests, response, kernel operands)
// Parameters:
//   NREQ    : number of requesters (2..16)
//   TIMEOUT : last WAIT-state cycle index before the job is aborted (1..65535)
// -----------------------------------------------------------------------------
module fib_kernel_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fib_kernel_arbiter_if.slave   bus
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int SW = IW + 1;
    localparam logic [SW-1:0] NREQ_W    = SW'(NREQ);
    localparam logic [IW-1:0] PTR_RESET = IW'(NREQ - 1);
    localparam logic [15:0]   TIMEOUT_W = 16'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [15:0]   timer_q, timer_d;
    logic          resp_valid_q, resp_valid_d;
    logic [IW-1:0] resp_id_q, resp_id_d;
    logic [31:0]   resp_data_q, resp_data_d;
    logic          resp_err_q, resp_err_d;
    logic          busy_q, busy_d;
    logic          k_r_enable_q, k_r_enable_d;
    logic [5:0]    k_init_n_q, k_init_n_d;
    logic [31:0]   k_init_a_q, k_init_a_d;
    logic [31:0]   k_init_b_q, k_init_b_d;

    // Per-requester payload views
    logic [5:0]  n_arr [NREQ];
    logic [31:0] a_arr [NREQ];
    logic [31:0] b_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
            assign n_arr[gi] = bus.req_n[6*gi +: 6];
            assign a_arr[gi] = bus.req_a[32*gi +: 32];
            assign b_arr[gi] = bus.req_b[32*gi +: 32];
        end
    endgenerate

    // Round-robin search starting just above ptr. ptr < NREQ and k <= NREQ,
    // so a single conditional subtraction implements the wrap.
    logic [NREQ-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic            grant_found;
    logic [SW-1:0]   scan_idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_found = 1'b0;
        scan_idx    = '0;
        for (int k = 1; k <= NREQ; k++) begin
            scan_idx = {1'b0, ptr_q} + SW'(k);
            if (scan_idx >= NREQ_W) begin
                scan_idx = scan_idx - NREQ_W;
            end
            if (!grant_found && bus.req_valid[scan_idx[IW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[IW-1:0];
            end
        end
        if (grant_found) begin
            grant[grant_idx] = 1'b1;
        end
    end

    // Next-state and output computation
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        timer_d      = timer_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        busy_d       = busy_q;
        k_r_enable_d = 1'b0;
        k_init_n_d   = k_init_n_q;
        k_init_a_d   = k_init_a_q;
        k_init_b_d   = k_init_b_q;

        unique case (state_q)
            IDLE: begin
                // grant only contains valid requesters, so any grant is a transfer
                if (grant_found) begin
                    k_init_n_d   = n_arr[grant_idx];
                    k_init_a_d   = a_arr[grant_idx];
                    k_init_b_d   = b_arr[grant_idx];
                    resp_id_d    = grant_idx;
                    k_r_enable_d = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = START;
                end
            end
            START: begin
                timer_d = '0;
                state_d = WAIT;
            end
            WAIT: begin
                timer_d = timer_q + 16'd1;
                if (bus.k_w_enable == 1'b1) begin
                    resp_data_d  = bus.k_result;
                    resp_err_d   = 1'b0;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end else if (timer_q == TIMEOUT_W) begin
                    resp_data_d  = '0;
                    resp_err_d   = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    // served requester drops to lowest priority
                    ptr_d        = resp_id_q;
                    resp_valid_d = 1'b0;
                    busy_d       = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= PTR_RESET;
            timer_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= 1'b0;
            busy_q       <= 1'b0;
            k_r_enable_q <= 1'b0;
            k_init_n_q   <= '0;
            k_init_a_q   <= '0;
            k_init_b_q   <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            timer_q      <= timer_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
            busy_q       <= busy_d;
            k_r_enable_q <= k_r_enable_d;
            k_init_n_q   <= k_init_n_d;
            k_init_a_q   <= k_init_a_d;
            k_init_b_q   <= k_init_b_d;
        end
    end

    assign bus.req_ready    = (state_q == IDLE) ? grant : '0;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_id      = resp_id_q;
    assign bus.resp_data    = resp_data_q;
    assign bus.resp_err     = resp_err_q;
    assign bus.busy         = busy_q;
    assign bus.k_r_enable   = k_r_enable_q;
    assign bus.k_controlArr = 1'b0;
    assign bus.k_init_n     = k_init_n_q;
    assign bus.k_init_a     = k_init_a_q;
    assign bus.k_init_b     = k_init_b_q;

endmodule

// File: tb/tb_fib_kernel_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fib_kernel_arbiter
// Directed bench for fib_kernel_arbiter (NREQ=4, TIMEOUT=15) with a behavioural
// kernel stub that answers a configurable number of cycles after k_r_enable.
// -----------------------------------------------------------------------------
module tb_fib_kernel_arbiter;
    localparam int NREQ = 4;
    localparam int TOUT = 15;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fib_kernel_arbiter_if #(.NREQ(NREQ)) bus ();

    fib_kernel_arbiter #(.NREQ(NREQ), .TIMEOUT(TOUT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- kernel stub ----------------
    int          stub_lat  = 2;
    bit          stub_hang = 1'b0;
    int          stub_cnt  = 0;
    bit          stub_active = 1'b0;
    logic [31:0] stub_res;

    function automatic logic [31:0] kern(input logic [5:0] n, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, t;
        x = a;
        y = b;
        for (int i = 0; i < int'(n); i++) begin
            t = x + y;
            y = x;
            x = t;
        end
        return x;
    endfunction

    always @(posedge clk) begin
        bus.k_w_enable <= 1'b0;
        if (bus.k_r_enable) begin
            stub_res    <= kern(bus.k_init_n, bus.k_init_a, bus.k_init_b);
            stub_cnt    <= stub_lat;
            stub_active <= 1'b1;
        end else if (stub_active && !stub_hang) begin
            if (stub_cnt == 0) begin
                bus.k_w_enable <= 1'b1;
                bus.k_result   <= stub_res;
                stub_active    <= 1'b0;
            end else begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [5:0] n, input logic [31:0] a, input logic [31:0] b);
        bus.req_n[6*id +: 6]   = n;
        bus.req_a[32*id +: 32] = a;
        bus.req_b[32*id +: 32] = b;
    endtask

    // Runs one job from a negedge to the negedge after its response handshake.
    // keep: leave req_valid asserted after accept; bp: cycles of resp backpressure.
    task automatic run_job(input int id, input logic [5:0] n, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_data,
                           input bit exp_err, input bit keep, input int bp, output int lat);
        int  cyc;
        int  bad;
        bit  prev_wen;
        set_req(id, n, a, b);
        bus.req_valid[id] = 1'b1;
        if (bp > 0) bus.resp_ready = 1'b0;
        #1;
        cyc = 0;
        while (bus.req_ready == '0 && cyc < 50) begin
            @(negedge clk); #1;
            cyc++;
        end
        chk("grant_onehot", 32'(bus.req_ready), 32'(1) << id);
        // cycle T+1: START
        @(negedge clk);
        if (!keep) bus.req_valid[id] = 1'b0;
        chk("start_pulse", 32'(bus.k_r_enable), 1);
        chk("busy_start", 32'(bus.busy), 1);
        chk("req_ready_start", 32'(bus.req_ready), 0);
        chk("init_n", 32'(bus.k_init_n), 32'(n));
        chk("init_a", bus.k_init_a, a);
        chk("init_b", bus.k_init_b, b);
        // cycle T+2: first WAIT cycle
        @(negedge clk);
        chk("start_one_cycle", 32'(bus.k_r_enable), 0);
        cyc = 0;
        prev_wen = 1'b0;
        while (bus.resp_valid !== 1'b1 && cyc < 100) begin
            prev_wen = bus.k_w_enable;
            @(negedge clk);
            cyc++;
        end
        lat = 2 + cyc;
        chk("resp_valid", 32'(bus.resp_valid), 1);
        if (!exp_err) chk("resp_after_wen", 32'(prev_wen), 1);
        chk("resp_id", 32'(bus.resp_id), 32'(id));
        chk("resp_data", bus.resp_data, exp_data);
        chk("resp_err", 32'(bus.resp_err), 32'(exp_err));
        $display("job id=%0d n=%0d a=%0d b=%0d -> resp_id=%0d data=%0d err=%0d lat=%0d",
                 id, n, a, b, bus.resp_id, bus.resp_data, bus.resp_err, lat);
        if (bp > 0) begin
            bad = 0;
            for (int i = 0; i < bp; i++) begin
                @(negedge clk);
                if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'(id) ||
                    bus.resp_data !== exp_data || bus.req_ready !== '0)
                    bad++;
            end
            chk("bp_stable_cycles_bad", 32'(bad), 0);
            bus.resp_ready = 1'b1;
        end
        @(negedge clk);
        chk("resp_dropped", 32'(bus.resp_valid), 0);
        chk("idle_after_hs", 32'(bus.busy), 0);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        int          id;
        logic [5:0]  n;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs [6];
    int   rr_order [5];
    logic [31:0] rr_exp [4];

    initial begin
        int lat;
        int bad;

        vecs[0] = '{2, 6'd10, 32'd1, 32'd0, 32'd89};
        vecs[1] = '{0, 6'd0,  32'd7, 32'd3, 32'd7};
        vecs[2] = '{1, 6'd1,  32'd7, 32'd3, 32'd10};
        vecs[3] = '{3, 6'd2,  32'd7, 32'd3, 32'd17};
        vecs[4] = '{1, 6'd5,  32'd1, 32'd0, 32'd8};
        vecs[5] = '{0, 6'd3,  32'd2, 32'd5, 32'd16};
        rr_order = '{0, 1, 2, 3, 0};
        rr_exp   = '{32'd1, 32'd2, 32'd3, 32'd5};   // n=id+1, a=1, b=0

        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.req_n      = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.resp_ready = 1'b1;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_resp_valid", 32'(bus.resp_valid), 0);
        chk("rst_resp_id", 32'(bus.resp_id), 0);
        chk("rst_resp_data", bus.resp_data, 0);
        chk("rst_resp_err", 32'(bus.resp_err), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_k_r_enable", 32'(bus.k_r_enable), 0);
        chk("rst_k_init_n", 32'(bus.k_init_n), 0);
        chk("rst_k_init_a", bus.k_init_a, 0);
        chk("rst_k_init_b", bus.k_init_b, 0);
        chk("rst_controlArr", 32'(bus.k_controlArr), 0);
        chk("rst_req_ready_none", 32'(bus.req_ready), 0);
        // ptr resets to NREQ-1: with 1 and 2 valid, 1 wins
        bus.req_valid = 4'b0110;
        #1;
        chk("rst_grant_from0", 32'(bus.req_ready), 32'b0010);
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_job(vecs[v].id, vecs[v].n, vecs[v].a, vecs[v].b, vecs[v].exp_data,
                    1'b0, 1'b0, 0, lat);
        end

        // round robin from reset, all requesters continuously valid
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            set_req(i, 6'(i + 1), 32'd1, 32'd0);
        end
        bus.req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            run_job(rr_order[k], 6'(rr_order[k] + 1), 32'd1, 32'd0, rr_exp[rr_order[k]],
                    1'b0, 1'b1, 0, lat);
        end
        bus.req_valid = '0;
        @(negedge clk);

        // backpressure: ptr=0, requester 2 wins over bystander 3; then 3 is
        // accepted on the cycle after the handshake
        set_req(3, 6'd4, 32'd2, 32'd1);
        bus.req_valid[3] = 1'b1;
        run_job(2, 6'd10, 32'd1, 32'd0, 32'd89, 1'b0, 1'b0, 20, lat);
        chk("next_accept_ready", 32'(bus.req_ready), 32'b1000);
        run_job(3, 6'd4, 32'd2, 32'd1, 32'd13, 1'b0, 1'b0, 0, lat);

        // watchdog timeout
        stub_hang = 1'b1;
        run_job(1, 6'd5, 32'd1, 32'd0, 32'd0, 1'b1, 1'b0, 0, lat);
        chk("timeout_latency", 32'(lat), 32'(TOUT + 3));
        stub_hang = 1'b0;
        repeat (3) @(negedge clk);

        // reset mid-WAIT: late kernel completion must not produce a response
        stub_lat = 10;
        set_req(0, 6'd3, 32'd1, 32'd0);
        bus.req_valid[0] = 1'b1;
        #1;
        bad = 0;
        while (bus.req_ready[0] !== 1'b1 && bad < 50) begin
            @(negedge clk); #1;
            bad++;
        end
        chk("midrst_grant", 32'(bus.req_ready), 32'b0001);
        @(negedge clk);
        bus.req_valid[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
        end
        chk("midrst_no_resp_cycles_bad", 32'(bad), 0);
        chk("midrst_init_cleared", bus.k_init_a, 0);
        stub_lat = 2;
        run_job(1, 6'd10, 32'd1, 32'd0, 32'd89, 1'b0, 1'b0, 0, lat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "global timeout");
    end

endmodule
